// File: rtl/srio_pkg.sv
// Shared SRIO definitions: HELLO header field layout, NWRITE type codes and
// the packer state encoding.
package srio_pkg;

   localparam int unsigned ADDR_W = 34;
   localparam int unsigned TID_W  = 8;
   localparam int unsigned SIZE_W = 8;
   localparam int unsigned LEN_W  = 16;
   localparam int unsigned HDR_W  = 64;

   localparam logic [3:0] FTYPE_NWRITE = 4'h5;
   localparam logic [3:0] TTYPE_NWRITE = 4'h4;
   localparam logic [1:0] PRIO_DEFAULT = 2'b01;

   // LSB positions of the HELLO header fields
   localparam int unsigned HDR_TID_LSB   = 56;
   localparam int unsigned HDR_FTYPE_LSB = 52;
   localparam int unsigned HDR_TTYPE_LSB = 48;
   localparam int unsigned HDR_PRIO_LSB  = 45;
   localparam int unsigned HDR_CRF_BIT   = 44;
   localparam int unsigned HDR_SIZE_LSB  = 36;
   localparam int unsigned HDR_ADDR_LSB  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HDR   = 2'd1,
      DATA  = 2'd2,
      DRAIN = 2'd3
   } state_e;

endpackage

// File: rtl/srio_hello_hdr.sv
// Combinational HELLO header builder for NWRITE packets; reserved bits and
// CRF are driven to zero.
module srio_hello_hdr
   import srio_pkg::*;
(
   input  logic [TID_W-1:0]  tid_in,
   input  logic [SIZE_W-1:0] size_in,
   input  logic [ADDR_W-1:0] addr_in,
   output logic [HDR_W-1:0]  hdr_c
);

   always_comb begin
      hdr_c = '0;
      hdr_c[HDR_TID_LSB   +: TID_W]  = tid_in;
      hdr_c[HDR_FTYPE_LSB +: 4]      = FTYPE_NWRITE;
      hdr_c[HDR_TTYPE_LSB +: 4]      = TTYPE_NWRITE;
      hdr_c[HDR_PRIO_LSB  +: 2]      = PRIO_DEFAULT;
      hdr_c[HDR_CRF_BIT]             = 1'b0;
      hdr_c[HDR_SIZE_LSB  +: SIZE_W] = size_in;
      hdr_c[HDR_ADDR_LSB  +: ADDR_W] = addr_in;
   end

endmodule

// File: rtl/srio_nwr_packer.sv
// Packs write requests and their 64-bit payload into HELLO NWRITE packets on
// the SRIO ireq stream, splitting requests into segments of MAX_BYTES.
module srio_nwr_packer
   import srio_pkg::*;
#(
   parameter logic [15:0]       SRC_ID    = 16'h0001,
   parameter logic [15:0]       DEST_ID   = 16'h00FF,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 34'h0,
   parameter logic [ADDR_W-1:0] ADDR_SPAN = 34'h1_0000,
   parameter int unsigned       MAX_BYTES = 256
) (
   input  logic              clk_srio,
   input  logic              reset_srio,
   input  logic              nwr_req_in,
   input  logic [LEN_W-1:0]  length_in,
   input  logic [63:0]       data_in,
   input  logic              valid_in,
   input  logic              first_in,
   input  logic [7:0]        keep_in,
   input  logic              last_in,
   output logic              ready_out,
   output logic [63:0]       ireq_tdata,
   output logic              ireq_tvalid,
   output logic              ireq_tlast,
   output logic [7:0]        ireq_tkeep,
   output logic [31:0]       ireq_tuser,
   input  logic              ireq_tready,
   output logic              busy_out,
   output logic              len_err_out
);

   localparam int unsigned SEG_W  = 9;
   localparam int unsigned BEAT_W = 6;
   localparam logic [SEG_W-1:0] MAX_SEG = SEG_W'(MAX_BYTES);

   state_e              state_q, state_d;
   logic [TID_W-1:0]    tid_q, tid_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [SEG_W-1:0]    seg_q, seg_d;
   logic [HDR_W-1:0]    hdr_q, hdr_d;
   logic                len_err_q, len_err_d;

   logic [SIZE_W-1:0]   size_next_c;
   logic [HDR_W-1:0]    hdr_next_c;
   logic [BEAT_W-1:0]   sent_beats_c;
   logic                xfer_c;
   logic                seg_end_c;
   logic                req_final_c;
   logic                first_unused;

   assign first_unused = first_in;

   function automatic logic [SEG_W-1:0] seg_of(input logic [LEN_W-1:0] rem);
      if (rem > LEN_W'(MAX_BYTES)) return MAX_SEG;
      return SEG_W'(rem);
   endfunction

   function automatic logic [BEAT_W-1:0] beats_of(input logic [SEG_W-1:0] seg);
      return BEAT_W'((10'(seg) + 10'd7) >> 3);
   endfunction

   // Advance the address pointer, wrapping back to the window base
   function automatic logic [ADDR_W-1:0] addr_adv(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] n);
      logic [ADDR_W-1:0] sum;
      sum = a + n;
      return (sum >= BASE_ADDR + ADDR_SPAN) ? BASE_ADDR : sum;
   endfunction

   // Header for the next segment is built from next-state values so it is
   // already registered on the first HDR cycle.
   assign size_next_c = SIZE_W'(seg_of(rem_d) - SEG_W'(1));

   srio_hello_hdr u_hdr (
      .tid_in  (tid_d),
      .size_in (size_next_c),
      .addr_in (addr_d),
      .hdr_c   (hdr_next_c)
   );

   always_comb begin
      state_d      = state_q;
      tid_d        = tid_q;
      addr_d       = addr_q;
      rem_d        = rem_q;
      beat_d       = beat_q;
      seg_d        = seg_q;
      len_err_d    = 1'b0;
      ready_out    = 1'b0;
      ireq_tdata   = '0;
      ireq_tvalid  = 1'b0;
      ireq_tlast   = 1'b0;
      ireq_tkeep   = '0;
      ireq_tuser   = '0;
      xfer_c       = valid_in & ireq_tready;
      seg_end_c    = (beat_q == BEAT_W'(1));
      req_final_c  = seg_end_c && (rem_q == LEN_W'(seg_q));
      sent_beats_c = beats_of(seg_q) - beat_q + BEAT_W'(1);

      case (state_q)
         IDLE: begin
            if (nwr_req_in) begin
               if (length_in != '0) begin
                  rem_d   = length_in;
                  state_d = HDR;
               end else begin
                  len_err_d = 1'b1;
               end
            end
         end
         HDR: begin
            ireq_tdata  = hdr_q;
            ireq_tvalid = 1'b1;
            ireq_tkeep  = 8'hFF;
            ireq_tuser  = {SRC_ID, DEST_ID};
            if (ireq_tready) begin
               seg_d   = seg_of(rem_q);
               beat_d  = beats_of(seg_of(rem_q));
               state_d = DATA;
            end
         end
         DATA: begin
            ireq_tdata  = data_in;
            ireq_tvalid = valid_in;
            ready_out   = ireq_tready;
            ireq_tuser  = {SRC_ID, DEST_ID};
            ireq_tlast  = seg_end_c | last_in;
            ireq_tkeep  = (req_final_c | last_in) ? keep_in : 8'hFF;
            if (xfer_c) begin
               beat_d = beat_q - BEAT_W'(1);
               if (seg_end_c) begin
                  rem_d  = rem_q - LEN_W'(seg_q);
                  addr_d = addr_adv(addr_q, ADDR_W'(seg_q));
                  tid_d  = tid_q + TID_W'(1);
                  if (rem_d != '0) begin
                     state_d = HDR;
                  end else if (last_in) begin
                     state_d = IDLE;
                  end else begin
                     len_err_d = 1'b1;
                     state_d   = DRAIN;
                  end
               end else if (last_in) begin
                  // Stream ended before the segment did: account only for what was sent
                  addr_d    = addr_adv(addr_q, ADDR_W'(sent_beats_c) << 3);
                  tid_d     = tid_q + TID_W'(1);
                  rem_d     = '0;
                  len_err_d = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
         DRAIN: begin
            ready_out = 1'b1;
            if (valid_in && last_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign hdr_d       = hdr_next_c;
   assign busy_out    = (state_q != IDLE);
   assign len_err_out = len_err_q;

   always_ff @(posedge clk_srio or posedge reset_srio) begin
      if (reset_srio) begin
         state_q   <= IDLE;
         tid_q     <= '0;
         addr_q    <= BASE_ADDR;
         rem_q     <= '0;
         beat_q    <= '0;
         seg_q     <= '0;
         hdr_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tid_q     <= tid_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         beat_q    <= beat_d;
         seg_q     <= seg_d;
         hdr_q     <= hdr_d;
         len_err_q <= len_err_d;
      end
   end

endmodule

// File: tb/tb_srio_nwr_packer.sv
// Scoreboard bench for srio_nwr_packer: directed requests push expected ireq
// beats; a negedge monitor pops and compares every accepted beat.
module tb_srio_nwr_packer;

   localparam logic [31:0] TUSER_EXP = 32'h0001_00FF;

   typedef struct packed {
      logic [63:0] data;
      logic        last;
      logic [7:0]  keep;
   } beat_t;

   logic        clk_srio = 1'b0;
   logic        reset_srio = 1'b1;
   logic        nwr_req_in = 1'b0;
   logic [15:0] length_in = '0;
   logic [63:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        first_in = 1'b0;
   logic [7:0]  keep_in = '0;
   logic        last_in = 1'b0;
   logic        ready_out;
   logic [63:0] ireq_tdata;
   logic        ireq_tvalid;
   logic        ireq_tlast;
   logic [7:0]  ireq_tkeep;
   logic [31:0] ireq_tuser;
   logic        ireq_tready = 1'b1;
   logic        busy_out;
   logic        len_err_out;

   beat_t exp_q[$];
   beat_t e;
   int    tests = 0;
   int    errors = 0;
   int    cyc = 0;
   int    tlast_cyc = 0;
   int    len_err_seen = 0;
   logic  toggle_en = 1'b0;
   logic  chk_mirror = 1'b0;

   srio_nwr_packer #(.ADDR_SPAN(34'h300)) dut (
      .clk_srio    (clk_srio),
      .reset_srio  (reset_srio),
      .nwr_req_in  (nwr_req_in),
      .length_in   (length_in),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .first_in    (first_in),
      .keep_in     (keep_in),
      .last_in     (last_in),
      .ready_out   (ready_out),
      .ireq_tdata  (ireq_tdata),
      .ireq_tvalid (ireq_tvalid),
      .ireq_tlast  (ireq_tlast),
      .ireq_tkeep  (ireq_tkeep),
      .ireq_tuser  (ireq_tuser),
      .ireq_tready (ireq_tready),
      .busy_out    (busy_out),
      .len_err_out (len_err_out)
   );

   always #5 clk_srio = ~clk_srio;

   always @(posedge clk_srio) cyc <= cyc + 1;

   always @(posedge clk_srio) begin
      #1;
      ireq_tready = toggle_en ? ~ireq_tready : 1'b1;
   end

   // Monitor: every accepted ireq beat must match the head of the scoreboard
   always @(negedge clk_srio) begin
      if (len_err_out) len_err_seen = len_err_seen + 1;
      if (chk_mirror && ireq_tvalid && (ireq_tdata == data_in)) begin
         tests = tests + 1;
         if (ready_out !== ireq_tready) begin
            errors = errors + 1;
            $display("FAIL ready_mirror: ready_out=%b required %b", ready_out, ireq_tready);
         end
      end
      if (ireq_tvalid && ireq_tready) begin
         tests = tests + 1;
         if (exp_q.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_beat: got data=%h last=%b keep=%h, required none",
                     ireq_tdata, ireq_tlast, ireq_tkeep);
         end else begin
            e = exp_q.pop_front();
            if (ireq_tdata !== e.data || ireq_tlast !== e.last ||
                ireq_tkeep !== e.keep || ireq_tuser !== TUSER_EXP) begin
               errors = errors + 1;
               $display("FAIL beat: got data=%h last=%b keep=%h user=%h, required data=%h last=%b keep=%h user=%h",
                        ireq_tdata, ireq_tlast, ireq_tkeep, ireq_tuser,
                        e.data, e.last, e.keep, TUSER_EXP);
            end
            if (ireq_tlast) tlast_cyc = cyc;
         end
      end
   end

   function automatic logic [63:0] hdr_word(input logic [7:0] tid, input logic [7:0] size,
                                            input logic [33:0] addr);
      return {tid, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, size, 2'b00, addr};
   endfunction

   function automatic logic [63:0] pay(input int sid, input int i);
      return {8'(sid), 24'h5A5A5A, 32'(i)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic push_hdr(input logic [7:0] tid, input logic [7:0] size, input logic [33:0] addr);
      beat_t b;
      b.data = hdr_word(tid, size, addr);
      b.last = 1'b0;
      b.keep = 8'hFF;
      exp_q.push_back(b);
   endtask

   // n payload beats, tlast on the final one, which carries fkeep
   task automatic push_beats(input int sid, input int from, input int n, input logic [7:0] fkeep);
      beat_t b;
      for (int i = 0; i < n; i++) begin
         b.data = pay(sid, from + i);
         b.last = (i == n - 1);
         b.keep = (i == n - 1) ? fkeep : 8'hFF;
         exp_q.push_back(b);
      end
   endtask

   task automatic do_reset();
      reset_srio = 1'b1;
      nwr_req_in = 1'b0;
      valid_in   = 1'b0;
      last_in    = 1'b0;
      keep_in    = '0;
      toggle_en  = 1'b0;
      chk_mirror = 1'b0;
      repeat (2) @(posedge clk_srio);
      #1;
      reset_srio = 1'b0;
   endtask

   task automatic request(input logic [15:0] len);
      length_in  = len;
      nwr_req_in = 1'b1;
      @(posedge clk_srio);
      #1;
      nwr_req_in = 1'b0;
   endtask

   // Source n beats honouring ready_out; last_in on beat last_at (-1: never)
   task automatic send(input int sid, input int n, input int last_at, input logic [7:0] lkeep);
      int guard;
      for (int i = 0; i < n; i++) begin
         data_in  = pay(sid, i);
         valid_in = 1'b1;
         first_in = (i == 0);
         last_in  = (i == last_at);
         keep_in  = (i == last_at) ? lkeep : 8'hFF;
         guard = 0;
         do begin
            @(negedge clk_srio);
            guard++;
         end while (!ready_out && guard < 500);
         if (!ready_out) begin
            tests = tests + 1;
            errors = errors + 1;
            $display("FAIL send_timeout: sid %0d beat %0d got ready_out=0 required 1", sid, i);
            valid_in = 1'b0;
            last_in  = 1'b0;
            return;
         end
         @(posedge clk_srio);
         #1;
      end
      valid_in = 1'b0;
      last_in  = 1'b0;
      first_in = 1'b0;
      keep_in  = '0;
   endtask

   task automatic settle(input string name, input int err_base, input int err_exp);
      repeat (4) @(posedge clk_srio);
      #1;
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_len_err"}, 64'(len_err_seen - err_base), 64'(err_exp));
      chk({name, "_idle"}, 64'(busy_out), 64'd0);
   endtask

   initial begin
      int e0;
      int req_cyc;

      // Reset state
      #3;
      chk("rst_tvalid", 64'(ireq_tvalid), 64'd0);
      chk("rst_tdata", ireq_tdata, 64'd0);
      chk("rst_tlast_tkeep", {55'd0, ireq_tlast, ireq_tkeep}, 64'd0);
      chk("rst_tuser", 64'(ireq_tuser), 64'd0);
      chk("rst_ready_busy_err", {61'd0, ready_out, busy_out, len_err_out}, 64'd0);
      do_reset();

      // Single 64-byte segment, back-to-back beats
      e0 = len_err_seen;
      push_hdr(8'd0, 8'h3F, 34'h0);
      push_beats(1, 0, 8, 8'hFF);
      req_cyc = cyc;
      request(16'd64);
      chk("single_busy", 64'(busy_out), 64'd1);
      send(1, 8, 7, 8'hFF);
      settle("single", e0, 0);
      chk("single_latency", 64'(tlast_cyc - req_cyc), 64'd9);

      // 600 bytes -> 256 + 256 + 88
      do_reset();
      e0 = len_err_seen;
      push_hdr(8'd0, 8'hFF, 34'h000); push_beats(2, 0, 32, 8'hFF);
      push_hdr(8'd1, 8'hFF, 34'h100); push_beats(2, 32, 32, 8'hFF);
      push_hdr(8'd2, 8'h57, 34'h200); push_beats(2, 64, 11, 8'hFF);
      request(16'd600);
      send(2, 75, 74, 8'hFF);
      settle("segment", e0, 0);

      // 13 bytes, partial last beat
      do_reset();
      e0 = len_err_seen;
      push_hdr(8'd0, 8'h0C, 34'h0);
      push_beats(3, 0, 2, 8'h1F);
      request(16'd13);
      send(3, 2, 1, 8'h1F);
      settle("partial", e0, 0);

      // Backpressure on ireq_tready
      do_reset();
      e0 = len_err_seen;
      toggle_en  = 1'b1;
      chk_mirror = 1'b1;
      push_hdr(8'd0, 8'h1F, 34'h0);
      push_beats(4, 0, 4, 8'hFF);
      request(16'd32);
      send(4, 4, 3, 8'hFF);
      settle("backpressure", e0, 0);
      toggle_en  = 1'b0;
      chk_mirror = 1'b0;

      // Zero length: error pulse, no traffic
      do_reset();
      e0 = len_err_seen;
      request(16'd0);
      chk("zero_len_busy", 64'(busy_out), 64'd0);
      settle("zero_len", e0, 1);

      // Early last_in on beat 5 of 8, then next packet at TID 1, addr 0x28
      do_reset();
      e0 = len_err_seen;
      push_hdr(8'd0, 8'h3F, 34'h0);
      push_beats(5, 0, 5, 8'hFF);
      request(16'd64);
      send(5, 5, 4, 8'hFF);
      settle("early_last", e0, 1);
      push_hdr(8'd1, 8'h07, 34'h28);
      push_beats(6, 0, 1, 8'h03);
      request(16'd8);
      send(6, 1, 0, 8'h03);
      settle("after_early", e0, 1);

      // Stream longer than request: excess beats drained
      do_reset();
      e0 = len_err_seen;
      push_hdr(8'd0, 8'h0F, 34'h0);
      push_beats(7, 0, 2, 8'hFF);
      request(16'd16);
      send(7, 4, 3, 8'hFF);
      settle("drain", e0, 1);
      push_hdr(8'd1, 8'h07, 34'h10);
      push_beats(8, 0, 1, 8'hFF);
      request(16'd8);
      send(8, 1, 0, 8'hFF);
      settle("after_drain", e0, 1);

      // Address window of 0x300: fourth 256-byte request wraps to 0
      do_reset();
      e0 = len_err_seen;
      for (int k = 0; k < 4; k++) begin
         push_hdr(8'(k), 8'hFF, (k == 3) ? 34'h0 : 34'(k * 256));
         push_beats(10 + k, 0, 32, 8'hFF);
         request(16'd256);
         send(10 + k, 32, 31, 8'hFF);
      end
      settle("wrap", e0, 0);

      // Reset in the middle of a data segment
      do_reset();
      push_hdr(8'd0, 8'h3F, 34'h0);
      push_beats(20, 0, 8, 8'hFF);
      request(16'd64);
      send(20, 3, -1, 8'hFF);
      data_in  = pay(20, 3);
      valid_in = 1'b1;
      keep_in  = 8'hFF;
      #1;
      chk("pre_rst_tvalid", 64'(ireq_tvalid), 64'd1);
      #1;
      reset_srio = 1'b1;
      #1;
      chk("mid_rst_tvalid_tlast", {62'd0, ireq_tvalid, ireq_tlast}, 64'd0);
      chk("mid_rst_tdata", ireq_tdata, 64'd0);
      chk("mid_rst_ready_busy", {62'd0, ready_out, busy_out}, 64'd0);
      chk("mid_rst_beats_left", 64'(exp_q.size()), 64'd5);
      exp_q.delete();
      valid_in = 1'b0;
      @(posedge clk_srio);
      #1;
      reset_srio = 1'b0;
      e0 = len_err_seen;
      push_hdr(8'd0, 8'h07, 34'h0);
      push_beats(21, 0, 1, 8'hFF);
      request(16'd8);
      send(21, 1, 0, 8'hFF);
      settle("after_reset", e0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
